// File: rtl/colour_pkg.sv
// Shared colour classification types for the colour detection and stabilisation path.
// Usable by any consumer of the centre-pixel detector flags.
package colour_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      RED   = 2'd1,
      GREEN = 2'd2,
      BLACK = 2'd3
   } colour_t;

   typedef enum logic [1:0] {
      S_NONE,
      S_CONFIRM,
      S_LOCKED
   } state_t;

   // Exactly one flag selects a colour; zero or several flags are ambiguous and read as NONE.
   function automatic colour_t classify(input logic r, input logic g, input logic b);
      colour_t c;
      unique case ({r, g, b})
         3'b100:  c = RED;
         3'b010:  c = GREEN;
         3'b001:  c = BLACK;
         default: c = NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/colour_stabiliser_if.sv
// Detector-flag input and stable-colour/event output bundle of colour_stabiliser.
// slave is the stabiliser side, master is the detector/game-logic side.
interface colour_stabiliser_if;

   logic       sample_valid;
   logic       red_detected;
   logic       green_detected;
   logic       black_detected;
   logic [1:0] colour_code;
   logic       colour_locked;
   logic       event_valid;
   logic [1:0] event_code;
   logic       event_ack;
   logic       event_overrun;

   modport master (
      output sample_valid, red_detected, green_detected, black_detected, event_ack,
      input  colour_code, colour_locked, event_valid, event_code, event_overrun
   );

   modport slave (
      input  sample_valid, red_detected, green_detected, black_detected, event_ack,
      output colour_code, colour_locked, event_valid, event_code, event_overrun
   );

endinterface

// File: rtl/colour_event_reg.sv
// Holding register for stable-colour change events with valid/ack handshake.
// Latest change wins; overrun is sticky until an ack clears it.
module colour_event_reg
   import colour_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  colour_t    load_code,
   input  logic       ack,
   output logic       event_valid,
   output logic [1:0] event_code,
   output logic       event_overrun
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_valid   <= 1'b0;
         event_code    <= '0;
         event_overrun <= 1'b0;
      end else if (load) begin
         event_valid <= 1'b1;
         event_code  <= load_code;
         // A pending, unacked event being replaced is an overrun; an ack in the same cycle clears it.
         if (event_valid) begin
            event_overrun <= !ack;
         end
      end else if (event_valid && ack) begin
         event_valid   <= 1'b0;
         event_overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/colour_stabiliser.sv
// Debounces per-frame colour flags into a stable colour with a change-event handshake.
// A colour is adopted after CONFIRM_FRAMES agreeing samples and dropped after LOST_FRAMES misses.
module colour_stabiliser
   import colour_pkg::*;
#(
   parameter int unsigned CONFIRM_FRAMES = 4,
   parameter int unsigned LOST_FRAMES    = 8,
   parameter int unsigned CNT_W          = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   colour_stabiliser_if.slave bus
);

   localparam logic [CNT_W-1:0] CONFIRM_N = CNT_W'(CONFIRM_FRAMES);
   localparam logic [CNT_W-1:0] LOST_N    = CNT_W'(LOST_FRAMES);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state,     state_n;
   colour_t          cand,      cand_n;
   colour_t          colour_q,  colour_n;
   logic [CNT_W-1:0] agree_cnt, agree_n;
   logic [CNT_W-1:0] miss_cnt,  miss_n;
   logic             locked_q;
   colour_t          raw;
   logic             ev_load;
   colour_t          ev_code;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_NONE;
         cand      <= NONE;
         colour_q  <= NONE;
         agree_cnt <= '0;
         miss_cnt  <= '0;
         locked_q  <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         colour_q  <= colour_n;
         agree_cnt <= agree_n;
         miss_cnt  <= miss_n;
         locked_q  <= (colour_n != NONE);
      end
   end

   always_comb begin
      state_n  = state;
      cand_n   = cand;
      colour_n = colour_q;
      agree_n  = agree_cnt;
      miss_n   = miss_cnt;
      ev_load  = 1'b0;
      ev_code  = NONE;
      raw      = classify(bus.red_detected, bus.green_detected, bus.black_detected);

      if (bus.sample_valid) begin
         unique case (state)
            S_NONE: begin
               if (raw != NONE) begin
                  cand_n  = raw;
                  agree_n = ONE;
                  state_n = S_CONFIRM;
               end
            end

            S_CONFIRM: begin
               if (raw == NONE) begin
                  agree_n = '0;
                  state_n = S_NONE;
               end else if (raw == cand) begin
                  agree_n = sat_inc(agree_cnt);
                  if (agree_n >= CONFIRM_N) begin
                     colour_n = cand;
                     state_n  = S_LOCKED;
                     agree_n  = '0;
                     miss_n   = '0;
                     ev_load  = 1'b1;
                     ev_code  = cand;
                  end
               end else begin
                  cand_n  = raw;
                  agree_n = ONE;
               end
            end

            S_LOCKED: begin
               if (raw == colour_q) begin
                  agree_n = '0;
                  miss_n  = '0;
               end else begin
                  miss_n = sat_inc(miss_cnt);
                  if (raw == NONE) begin
                     agree_n = '0;
                  end else if (raw == cand) begin
                     agree_n = sat_inc(agree_cnt);
                  end else begin
                     cand_n  = raw;
                     agree_n = ONE;
                  end
                  // Adoption of a new colour takes priority over losing the current one.
                  if (agree_n >= CONFIRM_N) begin
                     colour_n = cand_n;
                     agree_n  = '0;
                     miss_n   = '0;
                     ev_load  = 1'b1;
                     ev_code  = cand_n;
                  end else if (miss_n >= LOST_N) begin
                     colour_n = NONE;
                     state_n  = S_NONE;
                     agree_n  = '0;
                     miss_n   = '0;
                     ev_load  = 1'b1;
                     ev_code  = NONE;
                  end
               end
            end

            default: begin
               state_n = S_NONE;
            end
         endcase
      end
   end

   assign bus.colour_code   = colour_q;
   assign bus.colour_locked = locked_q;

   colour_event_reg u_event (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (ev_load),
      .load_code     (ev_code),
      .ack           (bus.event_ack),
      .event_valid   (bus.event_valid),
      .event_code    (bus.event_code),
      .event_overrun (bus.event_overrun)
   );

endmodule

// File: tb/tb_colour_stabiliser.sv
// Directed bench for colour_stabiliser: streak-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_colour_stabiliser;

   localparam int CONFIRM = 4;
   localparam int LOST    = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   colour_stabiliser_if bus ();

   colour_stabiliser #(
      .CONFIRM_FRAMES (CONFIRM),
      .LOST_FRAMES    (LOST),
      .CNT_W          (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: the stable colour, the current run of identical raw colours, and the
   // number of samples since the stable colour was last seen.
   typedef struct {
      int colour;
      int run_col;
      int run_len;
      int miss;
      int ev_valid;
      int ev_code;
      int ovr;
   } model_t;

   model_t m = '{default: 0};

   function automatic model_t step(input model_t s, input logic sv, input logic r,
                                   input logic g, input logic b, input logic ack);
      model_t n = s;
      int     nflags;
      int     raw;
      bit     chg = 1'b0;
      if (sv) begin
         nflags = int'(r) + int'(g) + int'(b);
         raw    = (nflags != 1) ? 0 : (r ? 1 : (g ? 2 : 3));
         if (n.colour != 0 && raw == n.colour) begin
            n.miss    = 0;
            n.run_len = 0;
         end else begin
            if (n.colour != 0) n.miss++;
            if (raw == 0) n.run_len = 0;
            else if (n.run_len > 0 && raw == n.run_col) n.run_len++;
            else begin
               n.run_col = raw;
               n.run_len = 1;
            end
            if (n.run_len >= CONFIRM) begin
               n.colour  = n.run_col;
               n.miss    = 0;
               n.run_len = 0;
               chg       = 1'b1;
            end else if (n.colour != 0 && n.miss >= LOST) begin
               n.colour  = 0;
               n.miss    = 0;
               n.run_len = 0;
               chg       = 1'b1;
            end
         end
      end
      if (chg) begin
         if (n.ev_valid != 0) n.ovr = ack ? 0 : 1;
         n.ev_valid = 1;
         n.ev_code  = n.colour;
      end else if (n.ev_valid != 0 && ack) begin
         n.ev_valid = 0;
         n.ovr      = 0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{default: 0};
      else m <= step(m, bus.sample_valid, bus.red_detected, bus.green_detected,
                     bus.black_detected, bus.event_ack);
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model.colour_code",   int'(bus.colour_code),   m.colour);
      check("model.colour_locked", int'(bus.colour_locked), (m.colour != 0) ? 1 : 0);
      check("model.event_valid",   int'(bus.event_valid),   m.ev_valid);
      check("model.event_code",    int'(bus.event_code),    m.ev_code);
      check("model.event_overrun", int'(bus.event_overrun), m.ovr);
   end

   // One strobe followed by an idle cycle whose flags differ, to show they are ignored.
   task automatic sample(input logic r, input logic g, input logic b, input logic ack);
      @(negedge clk);
      bus.sample_valid   = 1'b1;
      bus.red_detected   = r;
      bus.green_detected = g;
      bus.black_detected = b;
      bus.event_ack      = ack;
      @(negedge clk);
      bus.sample_valid   = 1'b0;
      bus.red_detected   = ~r;
      bus.green_detected = ~g;
      bus.black_detected = ~b;
      bus.event_ack      = 1'b0;
   endtask

   task automatic samples(input int n, input logic r, input logic g, input logic b);
      for (int i = 0; i < n; i++) sample(r, g, b, 1'b0);
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      bus.event_ack = 1'b1;
      @(negedge clk);
      bus.event_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.sample_valid   = 1'b0;
      bus.red_detected   = 1'b0;
      bus.green_detected = 1'b0;
      bus.black_detected = 1'b0;
      bus.event_ack      = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset.colour_code",   int'(bus.colour_code),   0);
      check("reset.colour_locked", int'(bus.colour_locked), 0);
      check("reset.event_valid",   int'(bus.event_valid),   0);
      check("reset.event_code",    int'(bus.event_code),    0);
      check("reset.event_overrun", int'(bus.event_overrun), 0);

      // Red confirmation needs four strobes.
      samples(3, 1'b1, 1'b0, 1'b0);
      check("red3.colour_code", int'(bus.colour_code), 0);
      sample(1'b1, 1'b0, 1'b0, 1'b0);
      check("red4.colour_code",   int'(bus.colour_code),   1);
      check("red4.colour_locked", int'(bus.colour_locked), 1);
      check("red4.event_valid",   int'(bus.event_valid),   1);
      check("red4.event_code",    int'(bus.event_code),    1);
      ack_pulse();
      check("ack1.event_valid", int'(bus.event_valid), 0);

      // Interleaved noise does not disturb a lock.
      sample(1'b1, 1'b0, 1'b0, 1'b0);
      sample(1'b0, 1'b1, 1'b0, 1'b0);
      sample(1'b1, 1'b0, 1'b0, 1'b0);
      sample(1'b1, 1'b0, 1'b0, 1'b0);
      check("alt.colour_code", int'(bus.colour_code), 1);
      check("alt.event_valid", int'(bus.event_valid), 0);

      // Locked-to-locked switch to green.
      samples(3, 1'b0, 1'b1, 1'b0);
      check("green3.colour_code", int'(bus.colour_code), 1);
      sample(1'b0, 1'b1, 1'b0, 1'b0);
      check("green4.colour_code", int'(bus.colour_code), 2);
      check("green4.event_valid", int'(bus.event_valid), 1);
      check("green4.event_code",  int'(bus.event_code),  2);
      ack_pulse();

      // Loss of lock after eight empty strobes.
      samples(7, 1'b0, 1'b0, 1'b0);
      check("lost7.colour_code", int'(bus.colour_code), 2);
      sample(1'b0, 1'b0, 1'b0, 1'b0);
      check("lost8.colour_code",   int'(bus.colour_code),   0);
      check("lost8.colour_locked", int'(bus.colour_locked), 0);
      check("lost8.event_valid",   int'(bus.event_valid),   1);
      check("lost8.event_code",    int'(bus.event_code),    0);
      ack_pulse();

      // Ambiguous red+black reads as NONE.
      samples(10, 1'b1, 1'b0, 1'b1);
      check("ambig.colour_code", int'(bus.colour_code), 0);
      check("ambig.event_valid", int'(bus.event_valid), 0);

      // Two changes without ack -> overrun, latest code kept.
      samples(4, 1'b1, 1'b0, 1'b0);
      samples(4, 1'b0, 1'b1, 1'b0);
      check("ovr.event_valid",   int'(bus.event_valid),   1);
      check("ovr.event_code",    int'(bus.event_code),    2);
      check("ovr.event_overrun", int'(bus.event_overrun), 1);
      ack_pulse();
      check("ovrack.event_valid",   int'(bus.event_valid),   0);
      check("ovrack.event_overrun", int'(bus.event_overrun), 0);

      // Change coinciding with ack keeps the event valid without overrun.
      samples(4, 1'b0, 1'b0, 1'b1);
      samples(3, 1'b0, 1'b0, 1'b1);
      samples(3, 1'b1, 1'b0, 1'b0);
      sample(1'b1, 1'b0, 1'b0, 1'b1);
      check("coack.event_valid",   int'(bus.event_valid),   1);
      check("coack.event_code",    int'(bus.event_code),    1);
      check("coack.event_overrun", int'(bus.event_overrun), 0);
      ack_pulse();
      ack_pulse();
      check("idleack.event_valid",   int'(bus.event_valid),   0);
      check("idleack.event_overrun", int'(bus.event_overrun), 0);

      // Asynchronous reset while confirming with an event pending.
      samples(8, 1'b0, 1'b0, 1'b0);
      samples(3, 1'b1, 1'b0, 1'b0);
      check("prerst.colour_code", int'(bus.colour_code), 0);
      check("prerst.event_valid", int'(bus.event_valid), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.colour_code",   int'(bus.colour_code),   0);
      check("midrst.colour_locked", int'(bus.colour_locked), 0);
      check("midrst.event_valid",   int'(bus.event_valid),   0);
      check("midrst.event_code",    int'(bus.event_code),    0);
      check("midrst.event_overrun", int'(bus.event_overrun), 0);
      #1 rst_n = 1'b1;
      samples(3, 1'b1, 1'b0, 1'b0);
      check("rered3.colour_code", int'(bus.colour_code), 0);
      sample(1'b1, 1'b0, 1'b0, 1'b0);
      check("rered4.colour_code", int'(bus.colour_code), 1);
      check("rered4.event_code",  int'(bus.event_code),  1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
